// File: rtl/mem_if_pkg.sv
// Shared definitions for the MAR/LDMAR/MDR memory initiator and related
// multi-cycle peripherals.
//   - state_t      : transaction FSM states of mem_access_unit
//   - ADDR_W_DEF   : default MAR / request address width
//   - DATA_W_DEF   : default MDR / data width
//   - LAT_CNT_W    : width of the access-latency down-counter
//   - lat_load()   : converts a latency in cycles to the counter preload value
package mem_if_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;
    localparam int LAT_CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        RESP    = 2'd3
    } state_t;

    // A wait state lasts while the counter walks from (lat-1) down to 0,
    // so a latency of N cycles preloads N-1.
    function automatic logic [LAT_CNT_W-1:0] lat_load(input int lat);
        return LAT_CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Bundle of every signal the memory initiator exchanges with its surroundings.
//   Request side : req_valid, req_ready, req_we, req_addr, req_wdata
//   Response side: rsp_valid, rsp_rdata
//   Memory side  : MAR, LDMAR, mem_we, mem_wdata, MDR
// Modports:
//   slave  - the mem_access_unit itself (accepts requests, drives the memory)
//   master - its environment: the MCU control path issuing requests and the
//            memory block answering on MDR
interface mem_access_unit_if
    import mem_if_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;

    logic [ADDR_W-1:0] MAR;
    logic              LDMAR;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] MDR;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, MDR,
        output req_ready, rsp_valid, rsp_rdata, MAR, LDMAR, mem_we, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, MDR,
        input  req_ready, rsp_valid, rsp_rdata, MAR, LDMAR, mem_we, mem_wdata
    );

endinterface

// File: rtl/mem_lat_counter.sv
// Loadable down-counter with zero flag, used to time fixed-latency accesses.
//   clk      : system clock
//   rst      : synchronous, active-high reset (count returns to 0)
//   load     : load load_val this cycle (has priority over dec)
//   load_val : preload value
//   dec      : decrement by one; saturates at zero
//   zero     : count is currently zero
module mem_lat_counter
    import mem_if_pkg::*;
#(
    parameter int W = LAT_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its inputs regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_access_unit.sv
// Initiator side of the MAR/LDMAR/MDR memory interface.
// Takes one read or write request at a time over a valid/ready handshake,
// presents the address on MAR, strobes LDMAR (read) or mem_we (write) for a
// fixed number of cycles, captures MDR at the end of a read, and reports
// completion with a one-cycle rsp_valid pulse.
//   clk : system clock
//   rst : synchronous, active-high reset
//   bus : mem_access_unit_if.slave (request, response and memory signals)
// Parameters: ADDR_W, DATA_W widths; RD_LAT / WR_LAT strobe lengths (1..15).
module mem_access_unit
    import mem_if_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    mem_access_unit_if.slave bus
);

    localparam logic [LAT_CNT_W-1:0] RD_LOAD = lat_load(RD_LAT);
    localparam logic [LAT_CNT_W-1:0] WR_LOAD = lat_load(WR_LAT);

    state_t            state_q;
    state_t            state_d;

    logic [ADDR_W-1:0] mar_q;
    logic              ldmar_q;
    logic              mem_we_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] rsp_rdata_q;

    logic              ready;
    logic              accept;
    logic              cnt_dec;
    logic              cnt_zero;
    logic              wait_done;

    // Ready is held low while rst is asserted even though the state is
    // already IDLE, so nothing is accepted on the reset edge.
    assign ready     = (state_q == IDLE) && !rst;
    assign accept    = bus.req_valid && ready;
    assign cnt_dec   = (state_q == RD_WAIT) || (state_q == WR_WAIT);
    assign wait_done = cnt_dec && cnt_zero;

    mem_lat_counter #(
        .W (LAT_CNT_W)
    ) u_lat_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (bus.req_we ? WR_LOAD : RD_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets its default before the case so every path assigns
    // it and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = bus.req_we ? WR_WAIT : RD_WAIT;
            RD_WAIT: if (cnt_zero) state_d = RESP;
            WR_WAIT: if (cnt_zero) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers. MAR deliberately keeps its value after a
    // transaction; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            mar_q       <= '0;
            ldmar_q     <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            if (accept) begin
                mar_q <= bus.req_addr;
                if (bus.req_we) begin
                    mem_wdata_q <= bus.req_wdata;
                    mem_we_q    <= 1'b1;
                end else begin
                    ldmar_q     <= 1'b1;
                end
            end
            if (wait_done && (state_q == RD_WAIT)) begin
                rsp_rdata_q <= bus.MDR;
                ldmar_q     <= 1'b0;
            end
            if (wait_done && (state_q == WR_WAIT)) begin
                mem_we_q    <= 1'b0;
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.MAR       = mar_q;
    assign bus.LDMAR     = ldmar_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit.
// Main DUT uses RD_LAT=2 / WR_LAT=1; two extra instances (RD_LAT=1 and 15)
// share the request inputs for the latency sweep.
module tb_mem_access_unit;
    import mem_if_pkg::*;

    localparam int RD_LAT = 2;
    localparam int WR_LAT = 1;

    logic clk;
    logic rst;

    mem_access_unit_if #(.ADDR_W(16), .DATA_W(16)) bus ();
    mem_access_unit_if #(.ADDR_W(16), .DATA_W(16)) lat1_bus ();
    mem_access_unit_if #(.ADDR_W(16), .DATA_W(16)) lat15_bus ();

    mem_access_unit #(.ADDR_W(16), .DATA_W(16), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
        .clk (clk), .rst (rst), .bus (bus)
    );
    mem_access_unit #(.ADDR_W(16), .DATA_W(16), .RD_LAT(1), .WR_LAT(1)) dut_lat1 (
        .clk (clk), .rst (rst), .bus (lat1_bus)
    );
    mem_access_unit #(.ADDR_W(16), .DATA_W(16), .RD_LAT(15), .WR_LAT(1)) dut_lat15 (
        .clk (clk), .rst (rst), .bus (lat15_bus)
    );

    assign lat1_bus.req_valid  = bus.req_valid;
    assign lat1_bus.req_we     = bus.req_we;
    assign lat1_bus.req_addr   = bus.req_addr;
    assign lat1_bus.req_wdata  = bus.req_wdata;
    assign lat15_bus.req_valid = bus.req_valid;
    assign lat15_bus.req_we    = bus.req_we;
    assign lat15_bus.req_addr  = bus.req_addr;
    assign lat15_bus.req_wdata = bus.req_wdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    logic [15:0] wmem   [256];
    bit          wvalid [256];

    function automatic logic [15:0] pattern(input logic [15:0] a);
        case (a)
            16'h0010: return 16'hBEEF;
            16'hFFFF: return 16'hFFFF;
            16'h0001: return 16'h1111;
            16'h0002: return 16'h2222;
            16'h0003: return 16'h3333;
            default:  return a ^ 16'h5A5A;
        endcase
    endfunction

    always @(posedge clk) begin
        if (bus.mem_we) begin
            wmem[bus.MAR[7:0]]   <= bus.mem_wdata;
            wvalid[bus.MAR[7:0]] <= 1'b1;
        end
    end

    always_comb begin
        bus.MDR = 16'h0000;
        if (bus.LDMAR)
            bus.MDR = wvalid[bus.MAR[7:0]] ? wmem[bus.MAR[7:0]] : pattern(bus.MAR);
    end
    always_comb begin
        lat1_bus.MDR = 16'h0000;
        if (lat1_bus.LDMAR) lat1_bus.MDR = pattern(lat1_bus.MAR);
    end
    always_comb begin
        lat15_bus.MDR = 16'h0000;
        if (lat15_bus.LDMAR) lat15_bus.MDR = pattern(lat15_bus.MAR);
    end

    // ---------------- checking ----------------
    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Strobes must never overlap, and a response never coincides with ready.
    always @(negedge clk) begin
        check("strobe_overlap", 32'(bus.LDMAR & bus.mem_we), 32'd0);
        check("rsp_ready_excl", 32'(bus.rsp_valid & bus.req_ready), 32'd0);
    end

    // One complete transaction on the main DUT with timing and data checks.
    task automatic do_txn(input string name, input logic we, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic [15:0] exp_rd);
        int  n;
        int  lat;
        int  ld_cnt;
        int  we_cnt;
        int  rsp_at;
        bit  stable;
        lat = we ? WR_LAT : RD_LAT;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, "_ready"}, 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        ld_cnt = 0; we_cnt = 0; rsp_at = -1; stable = 1'b1;
        for (int k = 1; k <= 20 && rsp_at < 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                // Inputs outside accept must be ignored.
                bus.req_valid = 1'b0;
                bus.req_addr  = ~addr;
                bus.req_wdata = ~wdata;
            end
            if (bus.LDMAR) begin
                ld_cnt++;
                if (bus.MAR !== addr) stable = 1'b0;
            end
            if (bus.mem_we) begin
                we_cnt++;
                if (bus.MAR !== addr || bus.mem_wdata !== wdata) stable = 1'b0;
            end
            if (bus.rsp_valid) rsp_at = k;
        end
        check({name, "_rsp_cycle"}, 32'(rsp_at), 32'(lat + 1));
        check({name, "_ldmar_cycles"}, 32'(ld_cnt), we ? 32'd0 : 32'(RD_LAT));
        check({name, "_we_cycles"}, 32'(we_cnt), we ? 32'(WR_LAT) : 32'd0);
        check({name, "_stable"}, 32'(stable), 32'd1);
        if (!we) check({name, "_rdata"}, 32'(bus.rsp_rdata), 32'(exp_rd));
        @(negedge clk);
        check({name, "_pulse_end"}, 32'(bus.rsp_valid), 32'd0);
        check({name, "_mar_hold"}, 32'(bus.MAR), 32'(addr));
        check({name, "_ready_again"}, 32'(bus.req_ready), 32'd1);
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int          pend;
        int          q;
        int          nr;
        int          rsp_t [3];
        logic [15:0] rsp_d [3];
        int          n;
        bit          seen;
        int          t_main, t_l1, t_l15;

        vecs[0] = '{"rd_0010",   1'b0, 16'h0010, 16'h0000, 16'hBEEF};
        vecs[1] = '{"wr_00a5",   1'b1, 16'h00A5, 16'h1234, 16'h0000};
        vecs[2] = '{"rd_00a5",   1'b0, 16'h00A5, 16'h0000, 16'h1234};
        vecs[3] = '{"rd_ffff",   1'b0, 16'hFFFF, 16'h0000, 16'hFFFF};
        vecs[4] = '{"wr_0042",   1'b1, 16'h0042, 16'hFFFF, 16'h0000};
        vecs[5] = '{"rd_0042",   1'b0, 16'h0042, 16'h0000, 16'hFFFF};
        vecs[6] = '{"rd_0077",   1'b0, 16'h0077, 16'h0000, 16'h5A2D};

        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 16'h0000;
        bus.req_wdata = 16'h0000;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst_ready",     32'(bus.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        check("rst_mar",       32'(bus.MAR),       32'd0);
        check("rst_ldmar",     32'(bus.LDMAR),     32'd0);
        check("rst_mem_we",    32'(bus.mem_we),    32'd0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(bus.req_ready), 32'd1);

        // ---- table-driven transactions ----
        for (int i = 0; i < 7; i++)
            do_txn(vecs[i].name, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd);

        // ---- back-pressure: three reads with req_valid held high ----
        @(negedge clk);
        bus.req_we = 1'b0; bus.req_addr = 16'h0001; bus.req_valid = 1'b1;
        pend = 0; q = 0; nr = 0;
        for (int c = 0; c < 40 && nr < 3; c++) begin
            if (c > 0) @(negedge clk);
            if (pend != 0) begin
                pend = 0;
                q++;
                if (q < 3) bus.req_addr = 16'(q + 1);
                else       bus.req_valid = 1'b0;
            end
            if (bus.rsp_valid) begin
                rsp_t[nr] = c;
                rsp_d[nr] = bus.rsp_rdata;
                nr++;
            end
            if (bus.req_valid && bus.req_ready) pend = 1;
        end
        bus.req_valid = 1'b0;
        check("bp_rsp_count", 32'(nr), 32'd3);
        if (nr == 3) begin
            check("bp_data0", 32'(rsp_d[0]), 32'h1111);
            check("bp_data1", 32'(rsp_d[1]), 32'h2222);
            check("bp_data2", 32'(rsp_d[2]), 32'h3333);
            check("bp_gap01", 32'(rsp_t[1] - rsp_t[0]), 32'(RD_LAT + 2));
            check("bp_gap12", 32'(rsp_t[2] - rsp_t[1]), 32'(RD_LAT + 2));
        end

        // ---- reset in the 2nd RD_WAIT cycle ----
        @(negedge clk);
        n = 0;
        while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
        bus.req_we = 1'b0; bus.req_addr = 16'h0010; bus.req_valid = 1'b1;
        check("mr_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("mr_ldmar_c1", 32'(bus.LDMAR), 32'd1);
        @(negedge clk);
        check("mr_ldmar_c2", 32'(bus.LDMAR), 32'd1);
        check("mr_mar_c2",   32'(bus.MAR),   32'h0010);
        rst = 1'b1;
        @(negedge clk);
        check("mr_ldmar_rst", 32'(bus.LDMAR),     32'd0);
        check("mr_mar_rst",   32'(bus.MAR),       32'd0);
        check("mr_rsp_rst",   32'(bus.rsp_valid), 32'd0);
        check("mr_ready_rst", 32'(bus.req_ready), 32'd0);
        check("mr_rdata_rst", 32'(bus.rsp_rdata), 32'd0);
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1'b1;
        end
        check("mr_no_rsp",   32'(seen),          32'd0);
        check("mr_idle_rdy", 32'(bus.req_ready), 32'd1);
        do_txn("mr_follow", 1'b0, 16'h0010, 16'h0000, 16'hBEEF);

        // ---- latency sweep: RD_LAT = 2, 1, 15 on the same request ----
        n = 0;
        while (!(bus.req_ready && lat1_bus.req_ready && lat15_bus.req_ready) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("sw_all_idle", 32'(bus.req_ready && lat1_bus.req_ready && lat15_bus.req_ready), 32'd1);
        bus.req_we = 1'b0; bus.req_addr = 16'h0003; bus.req_valid = 1'b1;
        @(posedge clk);
        t_main = -1; t_l1 = -1; t_l15 = -1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (k == 1) bus.req_valid = 1'b0;
            if (bus.rsp_valid && t_main < 0)       t_main = k;
            if (lat1_bus.rsp_valid && t_l1 < 0)    t_l1 = k;
            if (lat15_bus.rsp_valid && t_l15 < 0)  t_l15 = k;
        end
        check("sw_lat2_cycle",  32'(t_main), 32'd3);
        check("sw_lat1_cycle",  32'(t_l1),   32'd2);
        check("sw_lat15_cycle", 32'(t_l15),  32'd16);
        check("sw_lat1_rdata",  32'(lat1_bus.rsp_rdata),  32'h3333);
        check("sw_lat15_rdata", 32'(lat15_bus.rsp_rdata), 32'h3333);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Absolute time bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
